// File: rtl/timekeeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timekeeper_pkg
//  Description : Constants shared by the timekeeper and the alarm comparator.
//                Holds the field-select codes, the field limits and small
//                wrap-increment helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package timekeeper_pkg;

    // Field-select codes; code 3 means no field is selected.
    localparam logic [1:0] SELECT_SEC  = 2'd0;
    localparam logic [1:0] SELECT_MIN  = 2'd1;
    localparam logic [1:0] SELECT_HOUR = 2'd2;
    localparam logic [1:0] SELECT_NONE = 2'd3;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    // The limit is compared before adding, so an out-of-range value never
    // reaches a register.
    function automatic logic [5:0] wrap_inc6(input logic [5:0] val,
                                             input logic [5:0] max);
        return (val == max) ? 6'd0 : val + 6'd1;
    endfunction

    function automatic logic [4:0] wrap_inc5(input logic [4:0] val,
                                             input logic [4:0] max);
        return (val == max) ? 5'd0 : val + 5'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timekeeper_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : timekeeper_tick_gen
//  Description : Prescaler dividing clk down to a one-second advance strobe.
//                The count is held at zero while hold is high, so leaving
//                hold restarts a full TICK_DIV-cycle period.
//  Ports       : clk      - system clock
//                reset_n  - asynchronous active-low reset
//                hold     - freeze prescaler at zero, suppress advance
//                advance  - one-cycle strobe on the last prescaler count
//  Revision    : 1.0  initial release
// ============================================================================
module timekeeper_tick_gen #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic clk,
    input  logic reset_n,
    input  logic hold,
    output logic advance
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;
    logic             at_last;

    assign at_last = (count_q == LAST);
    // Hold takes priority so a set-mode entry on the wrap cycle drops the advance.
    assign advance = at_last && !hold;

    always_comb begin
        count_d = count_q + DIV_W'(1);
        if (hold || at_last) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timekeeper.sv
`default_nettype none
// ============================================================================
//  Module      : timekeeper
//  Description : Time-of-day core. Counts hh:mm:ss from a one-second strobe
//                and supports a set mode in which counting freezes and the
//                selected field is stepped on rising edges of increment.
//  Ports       : clk       - system clock
//                reset_n   - asynchronous active-low reset
//                set_mode  - 1 = counting frozen, stepping enabled
//                select    - field select (sec/min/hour, 3 = none)
//                increment - step request, rising-edge detected
//                sec/min/hour - registered time outputs
//                tick      - pulse in the cycle the new time is presented
//                day_wrap  - pulse with tick on 23:59:59 -> 00:00:00
//  Revision    : 1.0  initial release
// ============================================================================
module timekeeper
    import timekeeper_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       set_mode,
    input  logic [1:0] select,
    input  logic       increment,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       tick,
    output logic       day_wrap
);

    logic [5:0] sec_q,  sec_d;
    logic [5:0] min_q,  min_d;
    logic [4:0] hour_q, hour_d;
    logic       tick_q, tick_d;
    logic       day_wrap_q, day_wrap_d;
    logic       prev_inc_q, prev_inc_d;
    logic       advance;
    logic       inc_edge;

    timekeeper_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (set_mode),
        .advance (advance)
    );

    // prev_inc tracks increment every cycle, so an edge seen outside set
    // mode is consumed rather than carried into the next set-mode window.
    assign inc_edge = set_mode && increment && !prev_inc_q;

    always_comb begin
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        tick_d     = 1'b0;
        day_wrap_d = 1'b0;
        prev_inc_d = increment;

        if (advance) begin
            tick_d = 1'b1;
            sec_d  = wrap_inc6(sec_q, SEC_MAX);
            if (sec_q == SEC_MAX) begin
                min_d = wrap_inc6(min_q, MIN_MAX);
                if (min_q == MIN_MAX) begin
                    hour_d = wrap_inc5(hour_q, HOUR_MAX);
                    if (hour_q == HOUR_MAX) begin
                        day_wrap_d = 1'b1;
                    end
                end
            end
        end else if (inc_edge) begin
            // Manual steps wrap within their own field and never carry.
            case (select)
                SELECT_SEC:  sec_d  = wrap_inc6(sec_q, SEC_MAX);
                SELECT_MIN:  min_d  = wrap_inc6(min_q, MIN_MAX);
                SELECT_HOUR: hour_d = wrap_inc5(hour_q, HOUR_MAX);
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            tick_q     <= 1'b0;
            day_wrap_q <= 1'b0;
            // Reset high so an increment held through reset is not an edge.
            prev_inc_q <= 1'b1;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            tick_q     <= tick_d;
            day_wrap_q <= day_wrap_d;
            prev_inc_q <= prev_inc_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hour     = hour_q;
    assign tick     = tick_q;
    assign day_wrap = day_wrap_q;

endmodule
`default_nettype wire
